// File: rtl/uart_tx_frame.sv
// Oversampled UART transmitter with configurable data width, parity and stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry transmit FIFO in front of the FSM.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 tx_cmd,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("uart_tx_frame: OVERSAMPLE must be 4..64");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of two in 2..64");
  end

  logic [2:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     data_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;

  logic                 accept;
  logic                 pop;
  logic                 word_avail;
  logic [DATA_BITS-1:0] word_data;
  logic                 word_parity;
  logic                 period_end;
  logic                 last_stop;

  assign accept      = tx_cmd && tx_ready;
  assign period_end  = (bit_cnt == CNT_LAST);
  assign last_stop   = (state == ST_STOP) && period_end && (stop_idx == STOP_LAST);
  assign pop         = word_avail && ((state == ST_IDLE) || last_stop);
  assign word_parity = (^word_data) ^ ODD;
  assign tx_busy     = (state != ST_IDLE);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] FIFO_FULL = FIFO_DEPTH[AW:0];

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [AW:0]          fifo_count;

  // The extra pointer bit separates full from empty when the indices match.
  assign fifo_count = wr_ptr - rd_ptr;
  assign tx_ready   = (fifo_count != FIFO_FULL);
  assign word_avail = (fifo_count != '0);
  assign word_data  = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge bclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge bclk) begin
    if (accept) fifo_mem[wr_ptr[AW-1:0]] <= din;
  end
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  // Ready drops as soon as a word is held so a second strobe cannot overwrite it.
  assign tx_ready   = (state == ST_IDLE) && !hold_valid;
  assign word_avail = hold_valid;
  assign word_data  = hold_data;

  always_ff @(posedge bclk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= din;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // txd is registered and updated together with each state change, so it never glitches.
  always_ff @(posedge bclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      data_idx   <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
    end else if (pop) begin
      state      <= ST_START;
      bit_cnt    <= '0;
      shift      <= word_data;
      parity_bit <= word_parity;
      txd        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          txd     <= 1'b1;
        end
        ST_START: begin
          if (period_end) begin
            bit_cnt  <= '0;
            data_idx <= '0;
            state    <= ST_DATA;
            txd      <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (period_end) begin
            bit_cnt <= '0;
            if (data_idx == IDX_LAST) begin
              if (PARITY != 0) begin
                state <= ST_PARITY;
                txd   <= parity_bit;
              end else begin
                state    <= ST_STOP;
                stop_idx <= 1'b0;
                txd      <= 1'b1;
              end
            end else begin
              data_idx <= data_idx + IDX_ONE;
              shift    <= shift >> 1;
              txd      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (period_end) begin
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            state    <= ST_STOP;
            txd      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (period_end) begin
            bit_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              state <= ST_IDLE;
              txd   <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: three frame formats compared every cycle against a frame-level model.
// Define UART_TX_FIFO_EN for both bench and RTL to exercise the FIFO variant.
module tb_uart_tx_frame;

  localparam int NCH = 3;

  typedef struct {
    int         start;
    logic [8:0] word;
  } frame_t;

  logic                bclk = 1'b0;
  logic                rst  = 1'b1;
  logic [NCH-1:0]      cmd;
  logic [NCH-1:0][8:0] din;
  logic [NCH-1:0]      ready;
  logic [NCH-1:0]      busy;
  logic [NCH-1:0]      txd;
  bit                  check_en = 1'b0;
  int                  n_checks = 0;
  int                  n_fails  = 0;

  always #5 bclk = ~bclk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Value of frame bit idx: start bit, data LSB first, optional parity, then stop/idle ones.
  function automatic logic frame_bit(input logic [8:0] w, input int idx, input int db,
                                     input int par);
    logic p;
    p = 1'b0;
    for (int i = 0; i < db; i++) p = p ^ w[i];
    if (idx == 0) return 1'b0;
    if (idx <= db) return w[idx-1];
    if (par != 0 && idx == db + 1) return (par == 2) ? ~p : p;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int DB    = (g == 0) ? 8  : (g == 1) ? 7 : 9;
    localparam int PAR   = (g == 0) ? 0  : (g == 1) ? 2 : 1;
    localparam int SB    = (g == 1) ? 2  : 1;
    localparam int OS    = (g == 0) ? 16 : (g == 1) ? 4 : 5;
    localparam int DEPTH = (g == 0) ? 8  : (g == 1) ? 4 : 2;
    localparam int FL    = OS * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

    uart_tx_frame #(
      .DATA_BITS (DB),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .OVERSAMPLE(OS),
      .FIFO_DEPTH(DEPTH)
    ) dut (
      .bclk    (bclk),
      .rst     (rst),
      .din     (din[g][DB-1:0]),
      .tx_cmd  (cmd[g]),
      .tx_ready(ready[g]),
      .tx_busy (busy[g]),
      .txd     (txd[g])
    );

    frame_t q[$];
    int     edge_no   = 0;
    int     last_end  = 0;
    logic   exp_txd   = 1'b1;
    logic   exp_busy  = 1'b0;
    logic   exp_ready = 1'b1;

    // Each accepted word occupies [start, start+FL) edges; frames never overlap.
    always @(posedge bclk) begin
      int queued;
      int st;
      edge_no++;
      if (rst) begin
        q.delete();
        last_end  = 0;
        exp_txd   = 1'b1;
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
      end else begin
        if (cmd[g] && exp_ready) begin
          st = (last_end > edge_no + 1) ? last_end : edge_no + 1;
          q.push_back('{st, din[g]});
          last_end = st + FL;
        end
        while (q.size() > 0 && q[0].start + FL <= edge_no) void'(q.pop_front());
        exp_txd  = 1'b1;
        exp_busy = 1'b0;
        queued   = 0;
        foreach (q[i]) begin
          if (q[i].start <= edge_no) begin
            exp_busy = 1'b1;
            exp_txd  = frame_bit(q[i].word, (edge_no - q[i].start) / OS, DB, PAR);
          end else begin
            queued++;
          end
        end
`ifdef UART_TX_FIFO_EN
        exp_ready = (queued < DEPTH);
`else
        exp_ready = (edge_no >= last_end) && (queued == 0);
`endif
      end
    end

    always @(negedge bclk) begin
      if (check_en) begin
        check_output($sformatf("ch%0d_txd", g), 32'(txd[g]), 32'(exp_txd));
        check_output($sformatf("ch%0d_busy", g), 32'(busy[g]), 32'(exp_busy));
        check_output($sformatf("ch%0d_ready", g), 32'(ready[g]), 32'(exp_ready));
      end
    end
  end

  // Sends one word on a ready channel and samples the middle of each bit period.
  task automatic apply_stimulus(input int ch, input logic [8:0] w, input int os,
                                output int busy_len, output logic [15:0] bits);
    @(negedge bclk);
    din[ch] = w;
    cmd[ch] = 1'b1;
    @(negedge bclk);
    cmd[ch]  = 1'b0;
    busy_len = 0;
    bits     = '1;
    for (int j = 1; j < 300; j++) begin
      @(negedge bclk);
      if (busy[ch]) busy_len++;
      if ((j - 1) % os == os / 2 && (j - 1) / os < 16) bits[(j - 1) / os] = txd[ch];
    end
  endtask

  initial begin
    int          blen;
    int          npush;
    logic [15:0] bits;
    cmd = '0;
    din = '0;
    repeat (3) @(negedge bclk);
    check_en = 1'b1;
    @(negedge bclk);
    check_output("reset_txd", 32'(txd), 32'h7);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_ready", 32'(ready), 32'h7);
    rst = 1'b0;

    $display("[TB] idle after reset");
    repeat (500) @(negedge bclk);
    check_output("idle_txd", 32'(txd), 32'h7);
    check_output("idle_busy", 32'(busy), 32'h0);

    $display("[TB] single frames in each format");
    apply_stimulus(0, 9'h065, 16, blen, bits);
    check_output("8n1_bits", 32'(bits), 32'hFECA);
    check_output("8n1_busy_len", 32'(blen), 32'd160);
    apply_stimulus(1, 9'h043, 4, blen, bits);
    check_output("7o2_bits", 32'(bits), 32'hFE86);
    check_output("7o2_busy_len", 32'(blen), 32'd44);
    apply_stimulus(2, 9'h1E5, 5, blen, bits);
    check_output("9e1_bits", 32'(bits), 32'hFBCA);
    check_output("9e1_busy_len", 32'(blen), 32'd60);

`ifdef UART_TX_FIFO_EN
    $display("[TB] FIFO burst of ten strobes");
    npush = 4;
    blen  = 0;
    @(negedge bclk);
    for (int i = 0; i < 10; i++) begin
      din[0] = 9'(i);
      cmd[0] = 1'b1;
      @(negedge bclk);
      if (busy[0]) blen++;
      if (i == 7) check_output("burst_ready_not_full", 32'(ready[0]), 32'd1);
      if (i == 8) check_output("burst_ready_full", 32'(ready[0]), 32'd0);
    end
    cmd[0] = 1'b0;
    repeat (1600) begin
      @(negedge bclk);
      if (busy[0]) blen++;
    end
    check_output("burst_busy_len", 32'(blen), 32'd1440);
`else
    $display("[TB] second strobe while busy is dropped");
    npush = 1;
    @(negedge bclk);
    din[0] = 9'h0A5;
    cmd[0] = 1'b1;
    @(negedge bclk);
    cmd[0] = 1'b0;
    blen   = 0;
    for (int j = 1; j < 400; j++) begin
      @(negedge bclk);
      if (busy[0]) blen++;
      if (j == 20) begin
        din[0] = 9'h03C;
        cmd[0] = 1'b1;
      end
      if (j == 21) cmd[0] = 1'b0;
      if (j == 160) check_output("single_ready_last_stop", 32'(ready[0]), 32'd0);
      if (j == 161) check_output("single_ready_back", 32'(ready[0]), 32'd1);
    end
    check_output("single_busy_len", 32'(blen), 32'd160);
`endif

    $display("[TB] reset during data bit 3");
    @(negedge bclk);
    for (int i = 0; i < npush; i++) begin
      din[0] = 9'(8'h10 + i);
      cmd[0] = 1'b1;
      @(negedge bclk);
    end
    cmd[0] = 1'b0;
    repeat (70 - (npush - 1)) @(negedge bclk);
    rst = 1'b1;
    @(negedge bclk);
    rst = 1'b0;
    check_output("midreset_txd", 32'(txd[0]), 32'd1);
    check_output("midreset_busy", 32'(busy[0]), 32'd0);
    check_output("midreset_ready", 32'(ready[0]), 32'd1);
    repeat (20) @(negedge bclk);
    check_output("midreset_flushed", 32'(busy[0]), 32'd0);
    apply_stimulus(0, 9'h05A, 16, blen, bits);
    check_output("after_reset_bits", 32'(bits), 32'hFEB4);
    check_output("after_reset_busy_len", 32'(blen), 32'd160);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 6000; c++) begin
      @(negedge bclk);
      for (int ch = 0; ch < NCH; ch++) begin
        cmd[ch] = ($urandom_range(0, 3) == 0);
        din[ch] = 9'($urandom);
      end
      rst = (c == 3000);
    end
    cmd = '0;
    rst = 1'b0;
    repeat (3000) @(negedge bclk);
    check_output("drain_busy", 32'(busy), 32'h0);
    check_output("drain_txd", 32'(txd), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the DDS control/telemetry link. It serialises parallel words onto `txd` using a baud-oversampled clock. The frame format is configurable: data width, parity mode and stop-bit count. Words are accepted through a ready/command handshake, and an optional transmit FIFO lets the host queue several words back-to-back. The block sits between the command/status logic and the board UART pin, driven by the same oversampled `bclk` as the existing transmitter.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `PARITY`, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `OVERSAMPLE`, 16: `bclk` cycles per bit period; legal range 4–64.
- `FIFO_DEPTH`, 8: transmit FIFO entries; must be a power of two, 2–64. Used only with `UART_TX_FIFO_EN`.

Ports:
- `bclk`, in, 1: oversampled baud clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `din`, in, `DATA_BITS`: word to transmit; sent LSB first.
- `tx_cmd`, in, 1: write strobe; a word is accepted on a rising edge where `tx_cmd && tx_ready`.
- `tx_ready`, out, 1: block can accept a word this cycle.
- `tx_busy`, out, 1: a frame is on the line, or words are queued.
- `txd`, out, 1: serial output; idle high; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - A bit counter runs 0..`OVERSAMPLE`-1 within each bit period.
  - A data index runs 0..`DATA_BITS`-1.
  - A stop index runs 0..`STOP_BITS`-1.
- IDLE:
  - `txd`=1.
  - When a word is available (accepted strobe, or FIFO not empty), load the shift register, compute parity, and go to START.
- START: `txd`=0 for one bit period, then go to DATA.
- DATA:
  - `txd` = shift[0]; shift right at the end of each bit period.
  - After `DATA_BITS` periods, go to PARITY if `PARITY`≠0, otherwise go to STOP.
- PARITY:
  - `txd` = XOR of the data bits for even parity, inverted for odd parity.
  - Lasts one bit period.
- STOP:
  - `txd`=1 for `STOP_BITS` periods.
  - At the end, if another word is available, load it and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length in `bclk` cycles = `OVERSAMPLE`×(1+`DATA_BITS`+(`PARITY`≠0)+`STOP_BITS`).
- A `tx_cmd` strobe while `tx_ready`=0 is ignored: the word is dropped and there is no error flag.
- `din` is sampled only on the accepting edge and may change afterwards.
- Illegal parameter values are a `$error` at elaboration.

## Timing
- Reset values: `txd`=1, `tx_ready`=1, `tx_busy`=0, FSM=IDLE, all counters 0, FIFO empty.
- Reset mid-frame: on the reset edge `txd` returns to 1, the frame is abandoned and the FIFO is flushed. No partial stop bit is emitted.
- Latency: a word accepted on edge N drives the start bit on `txd` from edge N+1, provided the FSM is IDLE.
- `tx_busy` rises on edge N+1 after acceptance. It falls on the edge that ends the last stop bit when nothing is queued.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle, so frames are contiguous.
- Each bit period is exactly `OVERSAMPLE` cycles, with no jitter.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - A `FIFO_DEPTH`-entry FIFO sits in front of the FSM.
  - `tx_ready` = FIFO not full.
  - The FSM pops from the FIFO when it enters START.
  - A simultaneous push and pop when the FIFO is full is not possible, because `tx_ready`=0 while full.
  - A simultaneous push and pop when the FIFO is empty and the FSM is IDLE bypasses the FIFO, with latency unchanged.
- `UART_TX_FIFO_EN` undefined:
  - Single-word operation with no FIFO.
  - `tx_ready` = FSM in IDLE.
  - `tx_ready` goes low on the edge after acceptance and returns high with the IDLE entry after the last stop bit.

## Test plan
- Reset and idle (default parameters): release `rst`, hold `tx_cmd`=0 for 500 cycles -> `txd`=1, `tx_ready`=1, `tx_busy`=0 throughout.
- 8N1 frame: `din`=8'h65, one-cycle `tx_cmd` -> `txd` is 0 for 16 cycles, then 1,0,1,0,0,1,1,0 at 16 cycles each, then 1 for 16 cycles. Total 160 cycles; `tx_busy` is high for exactly 160 cycles.
- Parity and stop bits: `PARITY`=1, `STOP_BITS`=2 with `din`=8'h65 -> parity bit 0, frame 192 cycles. `PARITY`=2 -> parity bit 1. `DATA_BITS`=7, `PARITY`=0, `din`=7'h41 -> frame 144 cycles.
- FIFO burst (`UART_TX_FIFO_EN`, depth 8): push 9 words 8'h00–8'h08 on consecutive cycles.
  - All 9 are accepted: the first bypasses to the FSM, the remaining 8 fill the FIFO, then `tx_ready`=0.
  - A 10th strobe is dropped.
  - The 9 frames go out contiguously over 1440 cycles in order 00..08.
- No-FIFO build: strobe 8'hA5, then strobe 8'h3C 20 cycles later -> 8'h3C is dropped. `tx_ready` returns to 1 at cycle 161 after the first accept.
- Reset mid-frame: assert `rst` for one cycle during the DATA bit 3 period with the FIFO holding 3 words -> on the next edge `txd`=1, the FIFO is empty and `tx_busy`=0. Afterwards a fresh strobe of 8'h5A transmits correctly.
